// File: rtl/axis_rx_fifo_if.sv
// Stream-in / buffered-out handshake bundle for axis_rx_fifo.
// slave is the FIFO's view; master is the upstream source plus local consumer.
interface axis_rx_fifo_if #(
  parameter int unsigned DATA_W = 32
);
  logic              TVALID;
  logic [DATA_W-1:0] S_TDATA;
  logic              TREADY;
  logic              OUT_VALID;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_READY;

  modport slave (
    input  TVALID, S_TDATA, OUT_READY,
    output TREADY, OUT_VALID, OUT_DATA
  );

  modport master (
    output TVALID, S_TDATA, OUT_READY,
    input  TREADY, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/axis_rx_fifo.sv
// AXI4-Stream slave with a first-word-fall-through FIFO, word counter and wrapping checksum.
// TREADY depends only on registered level and reset, never on TVALID.
module axis_rx_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic                ACLK,
  input  logic                ARST,
  axis_rx_fifo_if.slave       bus,
  output logic [AW:0]         LEVEL,
  output logic [15:0]         WORD_COUNT,
  output logic [31:0]         CHECKSUM
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       sum_q, sum_d;
  logic              tready, out_valid;
  logic              push, pop;

  always_comb begin
    tready    = (level_q != (AW+1)'(DEPTH)) && !ARST;
    out_valid = (level_q != '0);
    push      = bus.TVALID && tready;
    pop       = out_valid && bus.OUT_READY;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    sum_d    = sum_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + 16'd1;
      sum_d    = sum_q + 32'(bus.S_TDATA);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      sum_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
    end
  end

  // Storage is left uncleared by reset; level alone decides what is valid.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.S_TDATA;
    end
  end

  assign bus.TREADY    = tready;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_DATA  = mem_q[rd_ptr_q];
  assign LEVEL         = level_q;
  assign WORD_COUNT    = count_q;
  assign CHECKSUM      = sum_q;

endmodule

// File: tb/tb_axis_rx_fifo.sv
// Self-checking bench for axis_rx_fifo: hand-computed vector table plus a queue model
// that predicts level/handshake/accounting and checks each popped word in order.
module tb_axis_rx_fifo;
  localparam int unsigned Depth = 4;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic [2:0]  LEVEL;
  logic [15:0] WORD_COUNT;
  logic [31:0] CHECKSUM;

  axis_rx_fifo_if #(.DATA_W(32)) bus ();

  axis_rx_fifo #(
    .DATA_W(32),
    .DEPTH (Depth),
    .AW    (2)
  ) dut (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .bus       (bus),
    .LEVEL     (LEVEL),
    .WORD_COUNT(WORD_COUNT),
    .CHECKSUM  (CHECKSUM)
  );

  always #5 ACLK = ~ACLK;

  int          total = 0;
  int          bad   = 0;
  int          n_pop = 0;
  logic [31:0] m_q[$];
  logic [15:0] m_cnt = '0;
  logic [31:0] m_sum = '0;
  bit          cur_arst, cur_tv, cur_ordy;
  logic [31:0] cur_d;

  typedef struct {
    bit          tv;
    logic [31:0] d;
    bit          ordy;
    logic [2:0]  lvl;
    bit          trdy;
    bit          ov;
    bit          chk_od;
    logic [31:0] od;
    logic [15:0] cnt;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit arst, input bit tv, input logic [31:0] d, input bit ordy);
    @(negedge ACLK);
    ARST          = arst;
    bus.TVALID    = tv;
    bus.S_TDATA   = d;
    bus.OUT_READY = ordy;
    cur_arst = arst;
    cur_tv   = tv;
    cur_d    = d;
    cur_ordy = ordy;
    #1;
  endtask

  task automatic check_model();
    bit trdy;
    trdy = (m_q.size() != Depth) && !cur_arst;
    chk("level", 32'(LEVEL), 32'(m_q.size()));
    chk("tready", 32'(bus.TREADY), 32'(trdy));
    chk("out_valid", 32'(bus.OUT_VALID), 32'(m_q.size() != 0));
    chk("word_count", 32'(WORD_COUNT), 32'(m_cnt));
    chk("checksum", CHECKSUM, m_sum);
  endtask

  task automatic advance();
    bit          trdy, push, pop;
    logic [31:0] exp_d;
    trdy = (m_q.size() != Depth) && !cur_arst;
    push = cur_tv && trdy;
    pop  = !cur_arst && (m_q.size() != 0) && cur_ordy;
    if (pop) begin
      exp_d = m_q.pop_front();
      chk("pop_data", bus.OUT_DATA, exp_d);
      n_pop++;
    end
    @(posedge ACLK);
    if (cur_arst) begin
      m_q.delete();
      m_cnt = '0;
      m_sum = '0;
      n_pop = 0;
    end else if (push) begin
      m_q.push_back(cur_d);
      m_cnt = m_cnt + 16'd1;
      m_sum = m_sum + cur_d;
    end
  endtask

  task automatic step(input bit arst, input bit tv, input logic [31:0] d, input bit ordy);
    drive(arst, tv, d, ordy);
    check_model();
    advance();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // tv, d, ordy | level, tready, out_valid, chk_od, out_data, count, checksum
    vecs = '{
      '{1'b1, 32'h11, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 16'd0, 32'h000},
      '{1'b1, 32'h22, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 32'h11, 16'd1, 32'h011},
      '{1'b1, 32'h33, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 32'h22, 16'd2, 32'h033},
      '{1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 32'h33, 16'd3, 32'h066},
      '{1'b0, 32'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 16'd3, 32'h066},
      '{1'b1, 32'hA0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 16'd3, 32'h066},
      '{1'b1, 32'hA1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 32'hA0, 16'd4, 32'h106},
      '{1'b1, 32'hA2, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 32'hA0, 16'd5, 32'h1A7},
      '{1'b1, 32'hA3, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 32'hA0, 16'd6, 32'h249},
      '{1'b1, 32'hA4, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 32'hA0, 16'd7, 32'h2EC},
      '{1'b1, 32'hA4, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 32'hA0, 16'd7, 32'h2EC},
      '{1'b1, 32'hA4, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 32'hA0, 16'd7, 32'h2EC},
      '{1'b1, 32'hA4, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 32'hA1, 16'd7, 32'h2EC},
      '{1'b1, 32'hA5, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 32'hA1, 16'd8, 32'h390},
      '{1'b1, 32'hA5, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 32'hA2, 16'd8, 32'h390},
      '{1'b0, 32'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 32'hA3, 16'd9, 32'h435},
      '{1'b0, 32'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 32'hA4, 16'd9, 32'h435},
      '{1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 32'hA5, 16'd9, 32'h435},
      '{1'b0, 32'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00, 16'd9, 32'h435}
    };

    bus.TVALID    = 1'b0;
    bus.S_TDATA   = '0;
    bus.OUT_READY = 1'b0;

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_tready_low", 32'(bus.TREADY), 32'h0);
    advance();
    step(1'b1, 1'b0, 32'h0, 1'b0);

    // Ordering, latency, fill to full, full-with-pop, drain.
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, vecs[i].tv, vecs[i].d, vecs[i].ordy);
      chk("tbl_level", 32'(LEVEL), 32'(vecs[i].lvl));
      chk("tbl_tready", 32'(bus.TREADY), 32'(vecs[i].trdy));
      chk("tbl_out_valid", 32'(bus.OUT_VALID), 32'(vecs[i].ov));
      if (vecs[i].chk_od) chk("tbl_out_data", bus.OUT_DATA, vecs[i].od);
      chk("tbl_word_count", 32'(WORD_COUNT), 32'(vecs[i].cnt));
      chk("tbl_checksum", CHECKSUM, vecs[i].sum);
      check_model();
      advance();
    end

    // Checksum wrap and zero-valued word.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0002, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0000, 1'b1);
    chk("sum_wrap", CHECKSUM, 32'h0000_0001);
    chk("sum_wrap_count", 32'(WORD_COUNT), 32'd2);
    check_model();
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("zero_word_count", 32'(WORD_COUNT), 32'd3);
    chk("zero_word_sum", CHECKSUM, 32'h0000_0001);
    check_model();
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with three words buffered and a transfer offered in the reset cycle.
    step(1'b0, 1'b1, 32'hB0, 1'b0);
    step(1'b0, 1'b1, 32'hB1, 1'b0);
    step(1'b0, 1'b1, 32'hB2, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_level", 32'(LEVEL), 32'd3);
    check_model();
    advance();
    drive(1'b1, 1'b1, 32'hB3, 1'b1);
    chk("in_rst_tready", 32'(bus.TREADY), 32'h0);
    check_model();
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_level", 32'(LEVEL), 32'd0);
    chk("post_rst_out_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("post_rst_count", 32'(WORD_COUNT), 32'd0);
    chk("post_rst_sum", CHECKSUM, 32'h0);
    chk("post_rst_tready", 32'(bus.TREADY), 32'h1);
    check_model();
    advance();

    // Sustained one-push-one-pop streaming across counter and pointer wrap.
    for (int i = 0; i < 70000; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("long_word_count", 32'(WORD_COUNT), 32'd4464);
    check_model();
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("long_pops", 32'(n_pop), 32'd70000);
    chk("long_level", 32'(LEVEL), 32'd0);
    check_model();
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_rx_fifo.md
# axis_rx_fifo

AXI4-Stream slave stage sitting directly downstream of the stream master: it accepts 32-bit words over the TVALID/TREADY handshake, buffers them in a small first-word-fall-through FIFO, and presents them to the local consumer on a valid/ready output port. It also keeps a running count and a wrapping checksum of every accepted word for link monitoring. Back-pressure from the consumer propagates upstream through TREADY.

## Interface
- DATA_W, 32: stream data width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- AW, 2: pointer width, log2(DEPTH).

- ACLK  in  1  clock; all logic on the rising edge.
- ARST  in  1  synchronous, active-high reset.
- TVALID  in  1  upstream word valid.
- S_TDATA  in  DATA_W  upstream word.
- TREADY  out  1  slave can accept a word this cycle.
- OUT_VALID  out  1  OUT_DATA holds the oldest buffered word.
- OUT_DATA  out  DATA_W  head of FIFO.
- OUT_READY  in  1  consumer takes the head word this cycle.
- LEVEL  out  AW+1  words currently buffered, 0..DEPTH.
- WORD_COUNT  out  16  accepted words since reset; wraps 0xFFFF -> 0.
- CHECKSUM  out  32  modulo-2^32 sum of accepted words since reset.

## Operation
- Push: an upstream transfer occurs on a rising edge where TVALID=1 and TREADY=1. S_TDATA is written at wr_ptr, wr_ptr increments modulo DEPTH, LEVEL increments.
- Pop: a downstream transfer occurs on a rising edge where OUT_VALID=1 and OUT_READY=1. rd_ptr increments modulo DEPTH, LEVEL decrements.
- Simultaneous push and pop: both pointers advance and LEVEL is unchanged.
- TREADY = (LEVEL != DEPTH) and not in reset. It is combinational from registered state only and must never depend on TVALID.
- OUT_VALID = (LEVEL != 0). OUT_DATA = mem[rd_ptr]. There is no input-to-output bypass.
- Full (LEVEL = DEPTH): TREADY=0. Upstream TVALID/S_TDATA are ignored, and there is no write and no count or checksum change. A pop in the same cycle frees an entry, and TREADY returns high the next cycle.
- Empty (LEVEL = 0): OUT_VALID=0 and OUT_READY is ignored. OUT_DATA is don't-care.
- Accounting: on every push, WORD_COUNT += 1 (wrapping) and CHECKSUM += S_TDATA (wrapping, carry discarded). Zero-valued words are accepted and counted like any other.
- Data ordering is strict FIFO. No word is dropped or duplicated.

## Timing
- Reset values (ARST=1 sampled at an edge): LEVEL=0, wr_ptr=rd_ptr=0, WORD_COUNT=0, CHECKSUM=0, OUT_VALID=0. TREADY=0 while ARST is high and 1 on the first cycle after ARST falls. FIFO contents are not cleared.
- Reset mid-operation discards all buffered words. Transfers presented in the reset cycle are not accepted.
- Latency: a word pushed at edge N appears on OUT_DATA with OUT_VALID=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one push and one pop per cycle are sustained indefinitely when OUT_READY is held at 1.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. LEVEL disambiguates full from empty.
- WORD_COUNT and CHECKSUM update on the same edge as the push and are visible the following cycle.

## Test plan
- Reset, then TVALID=1 with S_TDATA=0x11,0x22,0x33 and OUT_READY=1 -> OUT_DATA shows 0x11,0x22,0x33 on consecutive cycles, each one cycle after its push. WORD_COUNT=3, CHECKSUM=0x66, LEVEL returns to 0.
- OUT_READY=0, push 0xA0..0xA5 with TVALID held -> 4 words accepted, TREADY=0 once LEVEL=4, and 0xA4 is held upstream. Raising OUT_READY drains 0xA0..0xA3, then 0xA4 and 0xA5, in order.
- Full FIFO with TVALID=1 and OUT_READY=1 in the same cycle -> pop only, LEVEL=3, TREADY=1 the next cycle.
- Push 0xFFFFFFFF then 0x00000002 -> CHECKSUM=0x00000001. Push 0x00000000 -> WORD_COUNT increments and CHECKSUM is unchanged.
- Assert ARST with LEVEL=3 -> next cycle LEVEL=0, OUT_VALID=0, counters 0, TREADY=0 during reset and 1 after.
- 70000 continuous pushes with OUT_READY=1 -> WORD_COUNT=70000 mod 65536=4464, no data loss, pointers wrap correctly.
